// File: rtl/iso14443a_rx_pkg.sv
// Shared types and constants for the ISO14443-A reader-side Manchester decoder.
// Symbol codes are chosen to equal the {first half, second half} vote pair.
package iso14443a_rx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SOF  = 2'd1,
        DATA = 2'd2
    } rx_state_e;

    typedef enum logic [1:0] {
        SYM_NONE = 2'b00,
        SYM_ZERO = 2'b01,
        SYM_ONE  = 2'b10,
        SYM_ERR  = 2'b11
    } sym_e;

    localparam int SAMPLES_PER_BIT  = 8;
    localparam int SAMPLES_PER_HALF = 4;

    // Odd parity holds when the byte plus its parity bit carry an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/iso14443a_half_vote.sv
// Reduces the four qualified samples of one half-bit to a single value H.
// ISO14443A_RX_MAJORITY_EN selects a 2-of-4 vote; otherwise the sample at half index 1 is used.
module iso14443a_half_vote
    import iso14443a_rx_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       srst,
    input  logic       sample_en,
    input  logic       mod_det,
    input  logic [1:0] half_idx,
    output logic       half_done,
    output logic       half_val
);

    // The half completes on the qualified sample carrying its last index.
    always_comb begin
        half_done = sample_en && (half_idx == 2'(SAMPLES_PER_HALF - 1));
    end

`ifdef ISO14443A_RX_MAJORITY_EN
    logic [1:0] ones_r;
    logic [2:0] total_s;

    // Running count of modulated samples, restarting at half index 0.
    always_comb begin
        if (half_idx == 2'd0) begin
            total_s = {2'b00, mod_det};
        end else begin
            total_s = {1'b0, ones_r} + {2'b00, mod_det};
        end
        half_val = (total_s >= 3'd2);
    end

    // Holds the count of the samples already seen in this half.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ones_r <= 2'd0;
        end else if (srst) begin
            ones_r <= 2'd0;
        end else if (sample_en) begin
            ones_r <= total_s[1:0];
        end
    end
`else
    logic pick_r;

    // Only the sample at half index 1 matters; it is forwarded live or from pick_r.
    always_comb begin
        if (half_idx == 2'd1) begin
            half_val = mod_det;
        end else begin
            half_val = pick_r;
        end
    end

    // Captures the sample at half index 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pick_r <= 1'b0;
        end else if (srst) begin
            pick_r <= 1'b0;
        end else if (sample_en && (half_idx == 2'd1)) begin
            pick_r <= mod_det;
        end
    end
`endif

endmodule

// File: rtl/iso14443a_manchester_rx.sv
// ISO14443-A reader-side frame decoder: SOF alignment, Manchester symbol decode,
// LSB-first byte assembly with odd parity and end-of-frame detection. Build option: ISO14443A_RX_MAJORITY_EN.
module iso14443a_manchester_rx
    import iso14443a_rx_pkg::*;
#(
    parameter int MAX_BYTES = 64
) (
    input  logic       ck_1356meg,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       sample_stb,
    input  logic       mod_det,
    output logic [7:0] byte_data,
    output logic [3:0] byte_bits,
    output logic       byte_parity_ok,
    output logic       byte_valid,
    output logic       frame_start,
    output logic       frame_end,
    output logic       err_coding,
    output logic       err_overflow
);

    localparam int BCW = $clog2(MAX_BYTES + 1);

    rx_state_e      state_r;
    logic [2:0]     samp_idx_r;
    logic           h1_r;
    logic [7:0]     shift_r;
    logic [3:0]     bit_cnt_r;
    logic [BCW-1:0] byte_cnt_r;

    logic           stb_s;
    logic           vote_en_s;
    logic [1:0]     half_idx_s;
    logic           half_done_s;
    logic           half_val_s;
    logic           sym_done_s;
    sym_e           sym_s;
    logic           data_bit_s;
    logic [7:0]     next_shift_s;

    // In IDLE only a modulated window is accepted, and it becomes sample index 0 of the SOF.
    always_comb begin
        stb_s      = sample_stb & enable;
        vote_en_s  = stb_s & ((state_r != IDLE) | mod_det);
        if (state_r == IDLE) begin
            half_idx_s = 2'd0;
        end else begin
            half_idx_s = samp_idx_r[1:0];
        end
        sym_done_s = half_done_s && (samp_idx_r == 3'(SAMPLES_PER_BIT - 1)) && (state_r != IDLE);
        sym_s      = sym_e'({h1_r, half_val_s});
        data_bit_s = (sym_s == SYM_ONE);
    end

    // Insert the new data bit; the first bit of a byte clears the upper positions.
    always_comb begin
        next_shift_s = shift_r;
        if (bit_cnt_r == 4'd0) begin
            next_shift_s = {7'b0000000, data_bit_s};
        end else begin
            next_shift_s[bit_cnt_r[2:0]] = data_bit_s;
        end
    end

    iso14443a_half_vote u_half_vote (
        .clk       (ck_1356meg),
        .rst_n     (rst_n),
        .srst      (~enable),
        .sample_en (vote_en_s),
        .mod_det   (mod_det),
        .half_idx  (half_idx_s),
        .half_done (half_done_s),
        .half_val  (half_val_s)
    );

    // Frame FSM, bit/byte counters, shift register and registered outputs.
    always_ff @(posedge ck_1356meg or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= IDLE;
            samp_idx_r     <= 3'd0;
            h1_r           <= 1'b0;
            shift_r        <= 8'h00;
            bit_cnt_r      <= 4'd0;
            byte_cnt_r     <= '0;
            byte_data      <= 8'h00;
            byte_bits      <= 4'd0;
            byte_parity_ok <= 1'b0;
            byte_valid     <= 1'b0;
            frame_start    <= 1'b0;
            frame_end      <= 1'b0;
            err_coding     <= 1'b0;
            err_overflow   <= 1'b0;
        end else begin
            byte_valid  <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            if (!enable) begin
                state_r    <= IDLE;
                samp_idx_r <= 3'd0;
            end else if (vote_en_s) begin
                samp_idx_r <= samp_idx_r + 3'd1;
                if (state_r == IDLE) begin
                    state_r <= SOF;
                end
                if (half_done_s && (samp_idx_r == 3'd3)) begin
                    h1_r <= half_val_s;
                end
                if (sym_done_s) begin
                    case (state_r)
                        SOF: begin
                            if (sym_s == SYM_ONE) begin
                                frame_start  <= 1'b1;
                                err_coding   <= 1'b0;
                                err_overflow <= 1'b0;
                                bit_cnt_r    <= 4'd0;
                                byte_cnt_r   <= '0;
                                state_r      <= DATA;
                            end else begin
                                state_r <= IDLE;
                            end
                        end
                        DATA: begin
                            case (sym_s)
                                SYM_ERR: begin
                                    err_coding <= 1'b1;
                                    frame_end  <= 1'b1;
                                    state_r    <= IDLE;
                                end
                                SYM_NONE: begin
                                    // A trailing partial byte (or an unfinished parity slot) is flushed first.
                                    if (bit_cnt_r != 4'd0) begin
                                        byte_valid     <= 1'b1;
                                        byte_data      <= shift_r;
                                        byte_bits      <= bit_cnt_r;
                                        byte_parity_ok <= 1'b0;
                                    end
                                    frame_end <= 1'b1;
                                    state_r   <= IDLE;
                                end
                                default: begin
                                    if (bit_cnt_r == 4'd8) begin
                                        byte_valid     <= 1'b1;
                                        byte_data      <= shift_r;
                                        byte_bits      <= 4'd8;
                                        byte_parity_ok <= odd_parity_ok(shift_r, data_bit_s);
                                        bit_cnt_r      <= 4'd0;
                                        byte_cnt_r     <= byte_cnt_r + BCW'(1);
                                    end else if ((bit_cnt_r == 4'd0) && (byte_cnt_r == BCW'(MAX_BYTES))) begin
                                        err_overflow <= 1'b1;
                                        frame_end    <= 1'b1;
                                        state_r      <= IDLE;
                                    end else begin
                                        shift_r   <= next_shift_s;
                                        bit_cnt_r <= bit_cnt_r + 4'd1;
                                    end
                                end
                            endcase
                        end
                        default: begin
                            state_r <= IDLE;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_iso14443a_manchester_rx.sv
// Self-checking bench for iso14443a_manchester_rx: directed frame table, hand sequences
// for glitch/enable corners, and random frames checked against a frame-level event model.
module tb_iso14443a_manchester_rx;

    localparam int TB_MAX   = 2;
    localparam int WIN      = 16;
    localparam int EV_START = 0;
    localparam int EV_BYTE  = 1;
    localparam int EV_END   = 2;

    logic       clk        = 1'b0;
    logic       rst_n      = 1'b0;
    logic       enable     = 1'b0;
    logic       sample_stb = 1'b0;
    logic       mod_det    = 1'b0;
    logic [7:0] byte_data;
    logic [3:0] byte_bits;
    logic       byte_parity_ok;
    logic       byte_valid;
    logic       frame_start;
    logic       frame_end;
    logic       err_coding;
    logic       err_overflow;

    iso14443a_manchester_rx #(.MAX_BYTES(TB_MAX)) dut (
        .ck_1356meg     (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .sample_stb     (sample_stb),
        .mod_det        (mod_det),
        .byte_data      (byte_data),
        .byte_bits      (byte_bits),
        .byte_parity_ok (byte_parity_ok),
        .byte_valid     (byte_valid),
        .frame_start    (frame_start),
        .frame_end      (frame_end),
        .err_coding     (err_coding),
        .err_overflow   (err_overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         kind;
        logic [7:0] data;
        logic [3:0] bits;
        logic       pok;
        int         cyc;
    } ev_t;

    ev_t act_q[$];

    // Event log, sampled on the falling edge.
    always @(negedge clk) begin
        if (frame_start) act_q.push_back('{EV_START, 8'd0, 4'd0, 1'b0, cyc});
        if (byte_valid)  act_q.push_back('{EV_BYTE, byte_data, byte_bits, byte_parity_ok, cyc});
        if (frame_end)   act_q.push_back('{EV_END, 8'd0, 4'd0, 1'b0, cyc});
    end

    int n_checks = 0;
    int n_fail   = 0;
    int last_stb_cyc = 0;
    int sym_cyc[64];
    int r_nbytes;
    logic [7:0] r_data;
    logic [3:0] r_bits;
    logic       r_pok;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic send_window(input logic m);
        @(negedge clk);
        sample_stb   = 1'b1;
        mod_det      = m;
        last_stb_cyc = cyc + 1;
        @(negedge clk);
        sample_stb = 1'b0;
        for (int i = 0; i < WIN - 2; i++) begin
            mod_det = 1'($urandom);
            @(negedge clk);
        end
    endtask

    // pat[3] is sample index 0 of the half.
    task automatic send_half(input logic [3:0] pat);
        for (int i = 3; i >= 0; i--) send_window(pat[i]);
    endtask

    task automatic send_sym(input logic [1:0] s, input int k);
        send_half({4{s[1]}});
        send_half({4{s[0]}});
        sym_cyc[k] = last_stb_cyc;
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) send_window(1'b0);
    endtask

    task automatic compare_events(input int base, input ev_t exp_q[$]);
        int n_act;
        n_act = act_q.size() - base;
        check("event_count", n_act, exp_q.size());
        for (int i = 0; i < exp_q.size() && i < n_act; i++) begin
            check("ev_kind", act_q[base+i].kind, exp_q[i].kind);
            check("ev_cycle", act_q[base+i].cyc, sym_cyc[exp_q[i].cyc]);
            if (exp_q[i].kind == EV_BYTE) begin
                check("byte_data", act_q[base+i].data, exp_q[i].data);
                check("byte_bits", act_q[base+i].bits, exp_q[i].bits);
                check("byte_parity_ok", act_q[base+i].pok, exp_q[i].pok);
            end
        end
    endtask

    // Builds one frame from a byte-level description, predicts its events, sends it and compares.
    task automatic run_frame(input logic [23:0] dat, input int n_full, input logic par_inv,
                             input int n_part, input logic [7:0] part, input logic term_err);
        logic [1:0] syms[$];
        ev_t        exp_q[$];
        logic [7:0] b;
        logic [8:0] m9;
        logic       exp_cod, exp_ovf, done;
        int         base;
        exp_cod = 1'b0;
        exp_ovf = 1'b0;
        done    = 1'b0;
        syms.push_back(2'b10);
        exp_q.push_back('{EV_START, 8'd0, 4'd0, 1'b0, 0});
        for (int i = 0; i < n_full && !done; i++) begin
            b = dat[8*i +: 8];
            if (i == TB_MAX) begin
                syms.push_back(b[0] ? 2'b10 : 2'b01);
                exp_ovf = 1'b1;
                done    = 1'b1;
                exp_q.push_back('{EV_END, 8'd0, 4'd0, 1'b0, syms.size() - 1});
            end else begin
                for (int j = 0; j < 8; j++) syms.push_back(b[j] ? 2'b10 : 2'b01);
                syms.push_back(((~(^b)) ^ par_inv) ? 2'b10 : 2'b01);
                exp_q.push_back('{EV_BYTE, b, 4'd8, ~par_inv, syms.size() - 1});
            end
        end
        if (!done && n_full == TB_MAX && n_part > 0) begin
            syms.push_back(part[0] ? 2'b10 : 2'b01);
            exp_ovf = 1'b1;
            exp_q.push_back('{EV_END, 8'd0, 4'd0, 1'b0, syms.size() - 1});
        end else if (!done) begin
            for (int j = 0; j < n_part; j++) syms.push_back(part[j] ? 2'b10 : 2'b01);
            if (term_err) begin
                syms.push_back(2'b11);
                exp_cod = 1'b1;
            end else begin
                syms.push_back(2'b00);
                m9 = (9'd1 << n_part) - 9'd1;
                if (n_part > 0)
                    exp_q.push_back('{EV_BYTE, part & m9[7:0], 4'(n_part), 1'b0, syms.size() - 1});
            end
            exp_q.push_back('{EV_END, 8'd0, 4'd0, 1'b0, syms.size() - 1});
        end
        base = act_q.size();
        for (int k = 0; k < syms.size(); k++) send_sym(syms[k], k);
        gap(10);
        compare_events(base, exp_q);
        check("err_coding", err_coding, exp_cod);
        check("err_overflow", err_overflow, exp_ovf);
        r_nbytes = 0;
        for (int i = base; i < act_q.size(); i++) begin
            if (act_q[i].kind == EV_BYTE) begin
                r_nbytes++;
                r_data = act_q[i].data;
                r_bits = act_q[i].bits;
                r_pok  = act_q[i].pok;
            end
        end
    endtask

    typedef struct {
        logic [23:0] dat;
        int          n_full;
        logic        par_inv;
        int          n_part;
        logic [7:0]  part;
        logic        term_err;
        int          e_nbytes;
        logic [7:0]  e_data;
        logic [3:0]  e_bits;
        logic        e_pok;
        logic        e_cod;
        logic        e_ovf;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int   base;
        ev_t  eq[$];
        int   exp_n;

        vecs[0] = '{24'h000005, 1, 1'b0, 0, 8'h00, 1'b0, 1, 8'h05, 4'd8, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{24'h000005, 1, 1'b1, 0, 8'h00, 1'b0, 1, 8'h05, 4'd8, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{24'h000000, 0, 1'b0, 4, 8'h06, 1'b0, 1, 8'h06, 4'd4, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{24'h000000, 0, 1'b0, 3, 8'h05, 1'b1, 0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{24'h000000, 0, 1'b0, 0, 8'h00, 1'b0, 0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{24'h33A581, 3, 1'b0, 0, 8'h00, 1'b0, 2, 8'hA5, 4'd8, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{24'h00005A, 1, 1'b0, 8, 8'hC3, 1'b0, 2, 8'hC3, 4'd8, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{24'h00F00F, 2, 1'b0, 0, 8'h00, 1'b0, 2, 8'hF0, 4'd8, 1'b1, 1'b0, 1'b0};

        repeat (3) @(negedge clk);
        check("rst_byte_valid", byte_valid, 1'b0);
        check("rst_frame_start", frame_start, 1'b0);
        check("rst_frame_end", frame_end, 1'b0);
        check("rst_err_coding", err_coding, 1'b0);
        check("rst_err_overflow", err_overflow, 1'b0);
        check("rst_byte_data", byte_data, 8'h00);
        check("rst_byte_bits", byte_bits, 4'd0);
        check("rst_byte_parity_ok", byte_parity_ok, 1'b0);
        rst_n  = 1'b1;
        enable = 1'b1;
        gap(2);

        for (int v = 0; v < 8; v++) begin
            run_frame(vecs[v].dat, vecs[v].n_full, vecs[v].par_inv,
                      vecs[v].n_part, vecs[v].part, vecs[v].term_err);
            check("vec_nbytes", r_nbytes, vecs[v].e_nbytes);
            if (vecs[v].e_nbytes > 0) begin
                check("vec_data", r_data, vecs[v].e_data);
                check("vec_bits", r_bits, vecs[v].e_bits);
                check("vec_pok", r_pok, vecs[v].e_pok);
            end
            check("vec_err_coding", err_coding, vecs[v].e_cod);
            check("vec_err_overflow", err_overflow, vecs[v].e_ovf);
        end

        // Lone modulated window: rejected as a glitch.
        base = act_q.size();
        send_window(1'b1);
        gap(9);
        check("glitch_events", act_q.size() - base, 0);

        // Half pattern 1011: majority gives 1, the single-sample pick (index 1) gives 0.
        base = act_q.size();
        send_half(4'b1011);
        send_half(4'b0000);
        sym_cyc[0] = last_stb_cyc;
        send_sym(2'b00, 1);
        gap(9);
`ifdef ISO14443A_RX_MAJORITY_EN
        exp_n = 2;
`else
        exp_n = 0;
`endif
        check("vote_1011_events", act_q.size() - base, exp_n);
        if (exp_n == 2 && act_q.size() - base == 2) begin
            check("vote_1011_start", act_q[base].kind, EV_START);
            check("vote_1011_end_cyc", act_q[base+1].cyc, sym_cyc[1]);
        end

        // Sticky flag survives enable low.
        run_frame(24'h0, 0, 1'b0, 2, 8'h01, 1'b1);
        @(negedge clk);
        enable = 1'b0;
        send_window(1'b1);
        enable = 1'b1;
        check("sticky_kept", err_coding, 1'b1);
        gap(9);

        // Enable dropped mid-byte: no frame_end, then a clean frame decodes.
        base = act_q.size();
        send_sym(2'b10, 0);
        send_sym(2'b01, 1);
        send_sym(2'b10, 2);
        send_sym(2'b01, 3);
        send_half(4'b1111);
        @(negedge clk);
        enable = 1'b0;
        for (int i = 0; i < 3; i++) send_window(1'b1);
        enable = 1'b1;
        gap(10);
        check("en_drop_events", act_q.size() - base, 1);
        check("en_drop_err_coding", err_coding, 1'b0);
        run_frame(24'h00003C, 1, 1'b0, 0, 8'h00, 1'b0);

        // Sample arriving as enable falls is dropped, so SOF aligns to the next window.
        base = act_q.size();
        @(negedge clk);
        enable     = 1'b0;
        sample_stb = 1'b1;
        mod_det    = 1'b1;
        @(negedge clk);
        enable     = 1'b1;
        sample_stb = 1'b0;
        mod_det    = 1'b0;
        for (int i = 0; i < 3; i++) send_window(1'b1);
        for (int i = 0; i < 5; i++) send_window(1'b0);
        sym_cyc[0] = last_stb_cyc;
        send_sym(2'b00, 1);
        gap(9);
        eq.delete();
        eq.push_back('{EV_START, 8'd0, 4'd0, 1'b0, 0});
        eq.push_back('{EV_END, 8'd0, 4'd0, 1'b0, 1});
        compare_events(base, eq);

        // Random frames against the frame-level model.
        for (int r = 0; r < 10; r++) begin
            run_frame(24'($urandom), $urandom_range(0, 3), ($urandom_range(0, 3) == 0),
                      $urandom_range(0, 8), 8'($urandom), ($urandom_range(0, 4) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
